// File: rtl/memory_stage.sv
// Memory stage of the RV32I pipeline: data-memory access, load extension,
// writeback select and the ME/WB pipeline register.
module memory_stage #(
    parameter int DM_WORDS = 1024
) (
    input  logic        clk_me,
    input  logic        rst_me,
    input  logic [31:0] pc_next_me,
    input  logic [31:0] ALU_res_me,
    input  logic [31:0] RU_rs2_me,
    input  logic [4:0]  rd_me,
    input  logic [2:0]  dm_ctrl_me,
    input  logic [1:0]  RU_DM_write_src_me,
    input  logic        RUwrite_me,
    input  logic        dm_wr_me,
    output logic [31:0] RU_data_wb,
    output logic [4:0]  rd_wb,
    output logic        RUwrite_wb,
    output logic        err_wb,
    output logic [31:0] fwd_data_me
);
    localparam int IDX_W = $clog2(DM_WORDS);

    // No valid/ready handshake: one instruction is accepted every cycle.
    logic [31:0]      mem [DM_WORDS];
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic             access;
    logic             illegal;
    logic             misalign;
    logic             fault;
    logic [3:0]       byte_en;
    logic [31:0]      wr_data;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_data;
    logic [31:0]      wb_val;
    logic             unused_addr_bits;

    assign word_idx         = ALU_res_me[IDX_W+1:2];
    assign lane             = ALU_res_me[1:0];
    assign unused_addr_bits = ^ALU_res_me[31:IDX_W+2];
    assign access           = dm_wr_me | (RU_DM_write_src_me == 2'b01);

    always_comb begin
        illegal  = 1'b0;
        misalign = 1'b0;
        case (dm_ctrl_me)
            3'b000:         illegal = 1'b0;
            3'b001:         misalign = lane[0];
            3'b010:         misalign = (lane != 2'b00);
            3'b100:         illegal = dm_wr_me;  // unsigned codes are load-only
            3'b101: begin
                illegal  = dm_wr_me;
                misalign = lane[0];
            end
            default:        illegal = 1'b1;
        endcase
    end

    assign fault = access & (illegal | misalign);

    always_comb begin
        byte_en = 4'b0000;
        wr_data = RU_rs2_me;
        case (dm_ctrl_me)
            3'b000: begin
                byte_en = 4'b0001 << lane;
                wr_data = {4{RU_rs2_me[7:0]}};
            end
            3'b001: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{RU_rs2_me[15:0]}};
            end
            3'b010:  byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    // Memory is deliberately left out of reset; only the store is gated by it.
    always_ff @(posedge clk_me) begin
        if (!rst_me && dm_wr_me && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign rd_word = mem[word_idx];

    always_comb begin
        case (lane)
            2'b00:   rd_byte = rd_word[7:0];
            2'b01:   rd_byte = rd_word[15:8];
            2'b10:   rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    end

    always_comb begin
        load_data = 32'h0;
        if (!fault) begin
            case (dm_ctrl_me)
                3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
                3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
                3'b010:  load_data = rd_word;
                3'b100:  load_data = {24'h0, rd_byte};
                3'b101:  load_data = {16'h0, rd_half};
                default: load_data = 32'h0;
            endcase
        end
    end

    always_comb begin
        case (RU_DM_write_src_me)
            2'b00:   wb_val = ALU_res_me;
            2'b01:   wb_val = load_data;
            2'b10:   wb_val = pc_next_me;
            default: wb_val = 32'h0;
        endcase
    end

    assign fwd_data_me = wb_val;

    always_ff @(posedge clk_me) begin
        if (rst_me) begin
            RU_data_wb <= 32'h0;
            rd_wb      <= 5'd0;
            RUwrite_wb <= 1'b0;
            err_wb     <= 1'b0;
        end else begin
            RU_data_wb <= wb_val;
            rd_wb      <= rd_me;
            RUwrite_wb <= RUwrite_me & ~fault;
            err_wb     <= fault;
        end
    end

endmodule
